// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle event strobes into level pulses of
// programmable width, queueing events that arrive while a pulse is in flight.
module pulse_stretcher #(
  parameter int CNT_W  = 4,
  parameter int PEND_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PULSE_IN,
  input  logic [CNT_W-1:0]  STRETCH_LEN,
  input  logic              CLR_OVF,
  output logic              LVL_OUT,
  output logic              BUSY,
  output logic [PEND_W-1:0] PEND_CNT,
  output logic              OVERFLOW
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  HOLD_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  HOLD_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  hold_r, hold_nxt_s, len_m1_s;
  logic [PEND_W-1:0] pend_r, pend_nxt_s;
  logic              ovf_r, ovf_nxt_s;
  logic              lvl_r, lvl_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              direct_s, inc_s, dec_s, drop_s;

  // State, counters and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_IDLE;
      hold_r  <= HOLD_ZERO;
      pend_r  <= PEND_ZERO;
      ovf_r   <= 1'b0;
      lvl_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      hold_r  <= hold_nxt_s;
      pend_r  <= pend_nxt_s;
      ovf_r   <= ovf_nxt_s;
      lvl_r   <= lvl_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // Next state, hold count, pending queue and overflow flag
  always_comb begin
    state_nxt_s = state_r;
    hold_nxt_s  = hold_r;
    pend_nxt_s  = pend_r;
    drop_s      = 1'b0;
    // A zero length still yields a one-cycle pulse
    if (STRETCH_LEN == HOLD_ZERO) begin
      len_m1_s = HOLD_ZERO;
    end else begin
      len_m1_s = STRETCH_LEN - HOLD_ONE;
    end

    case (state_r)
      ST_IDLE: begin
        if (PULSE_IN) begin
          state_nxt_s = ST_HIGH;
          hold_nxt_s  = len_m1_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (hold_r != HOLD_ZERO) begin
          hold_nxt_s = hold_r - HOLD_ONE;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      ST_GAP: begin
        if ((pend_r != PEND_ZERO) || PULSE_IN) begin
          state_nxt_s = ST_HIGH;
          hold_nxt_s  = len_m1_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        hold_nxt_s  = HOLD_ZERO;
      end
    endcase

    // An input event bypasses the queue only when nothing is waiting ahead of it
    direct_s = PULSE_IN && ((state_r == ST_IDLE) ||
                            ((state_r == ST_GAP) && (pend_r == PEND_ZERO)));
    inc_s    = PULSE_IN && !direct_s;
    dec_s    = (state_r == ST_GAP) && (pend_r != PEND_ZERO);

    case ({inc_s, dec_s})
      2'b10: begin
        if (pend_r != PEND_MAX) begin
          pend_nxt_s = pend_r + PEND_ONE;
        end else begin
          drop_s = 1'b1;
        end
      end
      2'b01:   pend_nxt_s = pend_r - PEND_ONE;
      default: pend_nxt_s = pend_r;
    endcase

    if (drop_s) begin
      ovf_nxt_s = 1'b1;
    end else if (CLR_OVF) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // Output values derived from the upcoming state
  always_comb begin
    lvl_nxt_s  = (state_nxt_s == ST_HIGH);
    busy_nxt_s = (state_nxt_s != ST_IDLE) || (pend_nxt_s != PEND_ZERO);
  end

  assign LVL_OUT  = lvl_r;
  assign BUSY     = busy_r;
  assign PEND_CNT = pend_r;
  assign OVERFLOW = ovf_r;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: a pulse-schedule reference model
// (start edge, length, next free edge, queued count) is compared every cycle.
module tb_pulse_stretcher;

  localparam int CNT_W  = 4;
  localparam int PEND_W = 3;
  localparam int PMAX   = 7;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              PULSE_IN = 1'b0;
  logic [CNT_W-1:0]  STRETCH_LEN = 4'd0;
  logic              CLR_OVF = 1'b0;
  logic              LVL_OUT;
  logic              BUSY;
  logic [PEND_W-1:0] PEND_CNT;
  logic              OVERFLOW;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: edge index, current pulse window, first edge a new pulse may start
  int m_t, m_free, m_hs, m_he, m_pend;
  bit m_ovf, m_lvl, m_busy;

  pulse_stretcher #(.CNT_W(CNT_W), .PEND_W(PEND_W)) dut (
    .CLK(CLK), .RST(RST), .PULSE_IN(PULSE_IN), .STRETCH_LEN(STRETCH_LEN),
    .CLR_OVF(CLR_OVF), .LVL_OUT(LVL_OUT), .BUSY(BUSY), .PEND_CNT(PEND_CNT),
    .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_t = 0; m_free = 0; m_hs = 1; m_he = 0; m_pend = 0;
    m_ovf = 1'b0; m_lvl = 1'b0; m_busy = 1'b0;
  endtask

  function automatic logic [5:0] mvec();
    logic [2:0] p;
    p = m_pend[2:0];
    return {m_lvl, m_busy, p, m_ovf};
  endfunction

  // Drive one cycle of inputs, advance the model over the rising edge, settle
  task automatic step(input bit pin, input int len, input bit clr);
    int avail, l;
    bit drop;
    PULSE_IN = pin; STRETCH_LEN = len[3:0]; CLR_OVF = clr;
    @(posedge CLK);
    m_t++;
    avail = m_pend + (pin ? 1 : 0);
    if (m_t >= m_free && avail > 0) begin
      l = (len == 0) ? 1 : len;
      m_hs = m_t; m_he = m_t + l - 1; m_free = m_t + l + 1;
      avail--;
    end
    drop   = avail > PMAX;
    m_pend = drop ? PMAX : avail;
    m_ovf  = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_lvl  = (m_t >= m_hs) && (m_t <= m_he);
    m_busy = (m_t <= m_free - 1) || (m_pend != 0);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++;
    if ({LVL_OUT, BUSY, PEND_CNT, OVERFLOW} !== 6'b000000) begin
      n_err++;
      $display("FAIL reset_hold got=%b required=%b", {LVL_OUT, BUSY, PEND_CNT, OVERFLOW}, 6'b000000);
    end
    RST = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 5, 1'b0);
      n_cmp++;
      if ({LVL_OUT, BUSY, PEND_CNT, OVERFLOW} !== mvec()) begin
        n_err++;
        $display("FAIL reset_idle t=%0d got=%b required=%b", m_t, {LVL_OUT, BUSY, PEND_CNT, OVERFLOW}, mvec());
      end
    end
  endtask

  task automatic test_single();
    int highs = 0;
    for (int i = 0; i < 13; i++) begin
      step(i == 0, 5, 1'b0);
      if (LVL_OUT === 1'b1) highs++;
      n_cmp++;
      if ({LVL_OUT, BUSY, PEND_CNT, OVERFLOW} !== mvec()) begin
        n_err++;
        $display("FAIL single t=%0d got=%b required=%b", m_t, {LVL_OUT, BUSY, PEND_CNT, OVERFLOW}, mvec());
      end
    end
    n_cmp++;
    if (highs != 5) begin
      n_err++;
      $display("FAIL single_width got=%0d required=%0d", highs, 5);
    end
  endtask

  task automatic test_back_to_back();
    int highs = 0, rises = 0, peak = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(i < 3, 3, 1'b0);
      if (LVL_OUT === 1'b1) highs++;
      if (LVL_OUT === 1'b1 && prev === 1'b0) rises++;
      prev = LVL_OUT;
      if (int'(PEND_CNT) > peak) peak = int'(PEND_CNT);
      n_cmp++;
      if ({LVL_OUT, BUSY, PEND_CNT, OVERFLOW} !== mvec()) begin
        n_err++;
        $display("FAIL b2b t=%0d got=%b required=%b", m_t, {LVL_OUT, BUSY, PEND_CNT, OVERFLOW}, mvec());
      end
    end
    n_cmp++;
    if (highs != 9 || rises != 3 || peak != 2) begin
      n_err++;
      $display("FAIL b2b_summary got highs=%0d rises=%0d peak=%0d required 9/3/2", highs, rises, peak);
    end
  endtask

  task automatic test_zero_len();
    int highs = 0, rises = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 18; i++) begin
      step(i == 0 || (i >= 4 && i < 8), 0, 1'b0);
      if (LVL_OUT === 1'b1) highs++;
      if (LVL_OUT === 1'b1 && prev === 1'b0) rises++;
      prev = LVL_OUT;
      n_cmp++;
      if ({LVL_OUT, BUSY, PEND_CNT, OVERFLOW} !== mvec()) begin
        n_err++;
        $display("FAIL zero_len t=%0d got=%b required=%b", m_t, {LVL_OUT, BUSY, PEND_CNT, OVERFLOW}, mvec());
      end
    end
    n_cmp++;
    if (highs != 5 || rises != 5) begin
      n_err++;
      $display("FAIL zero_len_summary got highs=%0d rises=%0d required 5/5", highs, rises);
    end
  endtask

  task automatic test_overflow();
    int rises = 0, peak = 0, n = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 15, 1'b0);
      if (LVL_OUT === 1'b1 && prev === 1'b0) rises++;
      prev = LVL_OUT;
      if (int'(PEND_CNT) > peak) peak = int'(PEND_CNT);
      n_cmp++;
      if ({LVL_OUT, BUSY, PEND_CNT, OVERFLOW} !== mvec()) begin
        n_err++;
        $display("FAIL ovf_fill t=%0d got=%b required=%b", m_t, {LVL_OUT, BUSY, PEND_CNT, OVERFLOW}, mvec());
      end
    end
    while (m_busy && n < 300) begin
      step(1'b0, 15, 1'b0);
      n++;
      if (LVL_OUT === 1'b1 && prev === 1'b0) rises++;
      prev = LVL_OUT;
      n_cmp++;
      if ({LVL_OUT, BUSY, PEND_CNT, OVERFLOW} !== mvec()) begin
        n_err++;
        $display("FAIL ovf_drain t=%0d got=%b required=%b", m_t, {LVL_OUT, BUSY, PEND_CNT, OVERFLOW}, mvec());
      end
    end
    n_cmp++;
    if (rises != 8 || peak != 7 || OVERFLOW !== 1'b1 || n >= 300) begin
      n_err++;
      $display("FAIL ovf_summary got rises=%0d peak=%0d ovf=%b drain=%0d required 8/7/1/<300", rises, peak, OVERFLOW, n);
    end
    step(1'b0, 15, 1'b1);
    n_cmp++;
    if (OVERFLOW !== 1'b0 || mvec() !== {LVL_OUT, BUSY, PEND_CNT, OVERFLOW}) begin
      n_err++;
      $display("FAIL ovf_clear got=%b required=%b", {LVL_OUT, BUSY, PEND_CNT, OVERFLOW}, mvec());
    end
    // Refill; the tenth pulse drops in the same cycle CLR_OVF is asserted
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 15, i == 9);
      n_cmp++;
      if ({LVL_OUT, BUSY, PEND_CNT, OVERFLOW} !== mvec()) begin
        n_err++;
        $display("FAIL ovf_refill t=%0d got=%b required=%b", m_t, {LVL_OUT, BUSY, PEND_CNT, OVERFLOW}, mvec());
      end
    end
    n_cmp++;
    if (OVERFLOW !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set_wins got=%b required=%b", OVERFLOW, 1'b1);
    end
    n = 0;
    while (m_busy && n < 300) begin
      step(1'b0, 15, 1'b1);
      n++;
    end
    n_cmp++;
    if ({LVL_OUT, BUSY, PEND_CNT, OVERFLOW} !== 6'b000000 || n >= 300) begin
      n_err++;
      $display("FAIL ovf_drain2 got=%b required=%b cycles=%0d", {LVL_OUT, BUSY, PEND_CNT, OVERFLOW}, 6'b000000, n);
    end
  endtask

  task automatic test_reset_mid();
    int highs = 0;
    for (int i = 0; i < 4; i++) begin
      step(i == 0 || i == 2, 8, 1'b0);
      n_cmp++;
      if ({LVL_OUT, BUSY, PEND_CNT, OVERFLOW} !== mvec()) begin
        n_err++;
        $display("FAIL rst_mid_pre t=%0d got=%b required=%b", m_t, {LVL_OUT, BUSY, PEND_CNT, OVERFLOW}, mvec());
      end
    end
    PULSE_IN = 1'b0;
    #2 RST = 1'b0;
    #1;
    n_cmp++;
    if ({LVL_OUT, BUSY, PEND_CNT, OVERFLOW} !== 6'b000000) begin
      n_err++;
      $display("FAIL rst_mid_async got=%b required=%b", {LVL_OUT, BUSY, PEND_CNT, OVERFLOW}, 6'b000000);
    end
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    model_reset();
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 8, 1'b0);
      if (LVL_OUT === 1'b1) highs++;
      n_cmp++;
      if ({LVL_OUT, BUSY, PEND_CNT, OVERFLOW} !== mvec()) begin
        n_err++;
        $display("FAIL rst_mid_post t=%0d got=%b required=%b", m_t, {LVL_OUT, BUSY, PEND_CNT, OVERFLOW}, mvec());
      end
    end
    n_cmp++;
    if (highs != 0) begin
      n_err++;
      $display("FAIL rst_mid_residual got=%0d required=%0d", highs, 0);
    end
  endtask

  task automatic test_random();
    int len = 2;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 19) == 0) len = $urandom_range(0, 5);
      step($urandom_range(0, 99) < 35, len, $urandom_range(0, 39) == 0);
      n_cmp++;
      if ({LVL_OUT, BUSY, PEND_CNT, OVERFLOW} !== mvec()) begin
        n_err++;
        $display("FAIL random t=%0d got=%b required=%b", m_t, {LVL_OUT, BUSY, PEND_CNT, OVERFLOW}, mvec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_len();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Reverse of the level-to-pulse generator: converts single-cycle pulses on PULSE_IN into level pulses on LVL_OUT. Each level pulse is held high for a programmable number of cycles.
- Consecutive level pulses are always separated by at least one low cycle. A downstream edge detector or synchroniser therefore recovers exactly one event per input pulse.
- Pulses arriving while busy are queued in a saturating pending counter, not lost.
- Sits on the source side of slow-domain or off-chip event signalling (e.g. UART/ALU done strobes).

Parameters:
CNT_W, 4, width of STRETCH_LEN and internal hold counter
PEND_W, 3, width of pending-pulse counter; max queued = 2^PEND_W-1

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-low reset
PULSE_IN  input  1  event strobe, one event per cycle high (back-to-back highs = multiple events)
STRETCH_LEN  input  CNT_W  high-time in cycles for each level pulse; 0 treated as 1
CLR_OVF  input  1  synchronous clear of OVERFLOW
LVL_OUT  output  1  stretched level, registered
BUSY  output  1  high when state != IDLE or PEND_CNT != 0, registered
PEND_CNT  output  PEND_W  queued events not yet emitted, registered
OVERFLOW  output  1  sticky: event dropped because queue full, registered

Behaviour:
- Reset (RST low, async): state=IDLE, LVL_OUT=0, BUSY=0, PEND_CNT=0, OVERFLOW=0, hold counter=0. Reset mid-pulse aborts immediately; queued events are discarded.
- FSM states: IDLE, HIGH, GAP. LVL_OUT=1 exactly when state=HIGH.
- IDLE:
  - PULSE_IN=1 at edge k -> HIGH. Load hold counter with max(STRETCH_LEN,1)-1. LVL_OUT=1 from cycle k+1 (latency 1).
  - Otherwise stay in IDLE.
- HIGH:
  - Hold counter nonzero -> decrement, stay.
  - Hold counter = 0 -> GAP.
  - LVL_OUT is high for exactly L=max(STRETCH_LEN,1) cycles.
- GAP (exactly 1 cycle, LVL_OUT=0):
  - "start" = (PEND_CNT!=0) or PULSE_IN.
  - start -> HIGH with a new hold count.
  - Otherwise -> IDLE.
- STRETCH_LEN is sampled only on entry to HIGH. Changes mid-pulse do not affect the current pulse.
- Pending counter, computed every cycle:
  - inc = PULSE_IN and the event is not consumed directly. Direct consumption happens only in IDLE, or in GAP when PEND_CNT=0.
  - dec = GAP->HIGH transition taken with PEND_CNT!=0.
  - inc and dec together -> PEND_CNT unchanged.
  - inc only -> PEND_CNT+1 if below max. If at max, the event is dropped and OVERFLOW<=1.
  - dec only -> PEND_CNT-1.
- OVERFLOW: sticky until CLR_OVF=1. If CLR_OVF and a new drop occur in the same cycle, set wins (OVERFLOW=1).
- Ordering: events are emitted in arrival order, one HIGH period each. No event is merged with another while PEND_CNT < max.
- Throughput: one event per L+1 cycles sustained.
- BUSY = (next state != IDLE) or (next PEND_CNT != 0), registered alongside state.
- No combinational path from any input to any output.

Test Plan:
- Reset, then idle 10 cycles with PULSE_IN=0 -> LVL_OUT=0, BUSY=0, PEND_CNT=0, OVERFLOW=0 throughout.
- STRETCH_LEN=5, single PULSE_IN at cycle 10 -> LVL_OUT high cycles 11-15, low 16. BUSY low from cycle 17. PEND_CNT stays 0.
- STRETCH_LEN=3, PULSE_IN high cycles 10,11,12 (3 events) -> LVL_OUT high 11-13, 15-17, 19-21, low at 14 and 18. PEND_CNT peaks at 2, ends 0.
- STRETCH_LEN=0 -> treated as 1. Single pulse gives LVL_OUT high for exactly 1 cycle. Pulses every cycle for 4 cycles -> alternating 1/0 pattern of 4 high cycles.
- PEND_W=3, STRETCH_LEN=15, 10 back-to-back PULSE_IN cycles -> PEND_CNT saturates at 7, 2 events dropped, OVERFLOW=1 sticky. CLR_OVF pulse clears it. CLR_OVF coincident with a drop leaves OVERFLOW=1. Exactly 8 level pulses emitted.
- STRETCH_LEN=8, PULSE_IN at 10 and 12, RST low at cycle 14 -> LVL_OUT, BUSY, PEND_CNT drop to 0 asynchronously. After release, no residual pulses are emitted.
